mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's control FSM. Serves instruction fetches, loads and stores issued by the datapath over a valid/ready request and single-pulse response handshake.
- Owns a word-organised internal RAM with programmable wait states. Performs byte, halfword and word access, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal-size requests with an error response. No RAM access occurs on any errored request.

---
 rtl/mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core: a valid/ready request with a single-pulse
// response, a word-organised RAM behind programmable wait states, and sub-word load/store handling.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_write_en,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [2:0]            i_size,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [2:0]              size_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    accept;
  logic                    req_err;
  logic                    ram_we;
  logic [AW-1:0]           rd_idx;
  logic [AW-1:0]           wr_idx;
  logic [29:0]             word_idx;
  logic [DATA_WIDTH-1:0]   ram_rd_q;
  logic [DATA_WIDTH-1:0]   wd_aligned;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [NB-1:0]           be;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  assign accept = i_req_valid && (state_q == S_IDLE);

  // FSM state register and request latch
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= i_write_en;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        size_q  <= i_size;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);

  // Error classification from the latched request; evaluated while in ACCESS
  assign word_idx = addr_q[31:2];

  always_comb begin
    req_err = 1'b0;
    case (size_q)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = addr_q[0];
      3'b010:  req_err = |addr_q[1:0];
      3'b100:  req_err = we_q;
      3'b101:  req_err = we_q | addr_q[0];
      default: req_err = 1'b1;
    endcase
    if (word_idx >= 30'(DEPTH_WORDS)) begin
      req_err = 1'b1;
    end
  end

  // The RAM is read every cycle so the word is ready on entry to ACCESS; with no wait
  // states the accept cycle itself supplies the address straight from the request port.
  assign rd_idx = (state_q == S_IDLE) ? i_addr[AW+1:2] : addr_q[AW+1:2];
  assign wr_idx = addr_q[AW+1:2];
  assign ram_we = (state_q == S_ACCESS) && we_q && !req_err;

  always_ff @(posedge clk) begin
    ram_rd_q <= mem[rd_idx];
    if (ram_we) begin
      mem[wr_idx] <= merged;
    end
  end

  always_comb begin
    be         = '0;
    wd_aligned = wdata_q;
    case (size_q[1:0])
      2'b00: begin
        be         = NB'(1) << addr_q[1:0];
        wd_aligned = {NB{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = addr_q[1] ? NB'(4'b1100) : NB'(4'b0011);
        wd_aligned = {(NB/2){wdata_q[15:0]}};
      end
      default: be = '1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be[gi] ? wd_aligned[gi*8 +: 8] : ram_rd_q[gi*8 +: 8];
    end
  endgenerate

  assign shifted = ram_rd_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = '0;
    case (size_q)
      3'b000:  load_val = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = ram_rd_q;
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_val = '0;
    endcase
  end

  // Response data is captured once per request and held until the next ACCESS
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      rdata_q <= (req_err || we_q) ? '0 : load_val;
      err_q   <= req_err;
    end
  end

  assign o_rdata = rdata_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a 2-wait-state instance and a zero-wait instance
// driven with directed requests; a per-instance monitor checks every response pulse.
module tb_mem_responder;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;

  logic        v0 = 1'b0, we0 = 1'b0;
  logic [31:0] a0 = '0, wd0 = '0;
  logic [2:0]  sz0 = '0;
  logic        rdy0, rv0, er0;
  logic [31:0] rd0;

  logic        v1 = 1'b0, we1 = 1'b0;
  logic [31:0] a1 = '0, wd1 = '0;
  logic [2:0]  sz1 = '0;
  logic        rdy1, rv1, er1;
  logic [31:0] rd1;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned rc1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .arstn(arstn), .i_req_valid(v0), .o_req_ready(rdy0), .i_write_en(we0),
    .i_addr(a0), .i_wdata(wd0), .i_size(sz0), .o_rsp_valid(rv0), .o_rdata(rd0), .o_err(er0)
  );

  mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .arstn(arstn), .i_req_valid(v1), .o_req_ready(rdy1), .i_write_en(we1),
    .i_addr(a1), .i_wdata(wd1), .i_size(sz1), .o_rsp_valid(rv1), .o_rdata(rd1), .o_err(er1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic monitor_pop(input int sel, input logic err, input logic [31:0] rdata);
    exp_t e;
    checks++;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_rsp dut%0d: got pulse at cycle %0d expected none", sel, cyc);
      return;
    end
    e = (sel == 0) ? q0.pop_front() : q1.pop_front();
    if (e.cyc != cyc || e.err !== err || e.rdata !== rdata) begin
      errors++;
      $display("FAIL %s: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h",
               e.tag, cyc, err, rdata, e.cyc, e.err, e.rdata);
    end else begin
      $display("rsp %s dut%0d cyc=%0d err=%b rdata=%h", e.tag, sel, cyc, err, rdata);
    end
  endtask

  always @(negedge clk) if (arstn && rv0) monitor_pop(0, er0, rd0);
  always @(negedge clk) begin
    if (arstn && rv1) begin
      rc1.push_back(cyc);
      monitor_pop(1, er1, rd1);
    end
  end

  // Issue one request; returns on the negedge after the accepting posedge.
  task automatic req(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] size, input logic exp_err, input logic [31:0] exp_rd,
                     input bit push, input string tag);
    exp_t e;
    int   n;
    int   w;
    w = (sel == 0) ? 2 : 0;
    @(negedge clk);
    if (sel == 0) begin v0 = 1'b1; we0 = we; a0 = addr; wd0 = wdata; sz0 = size; end
    else          begin v1 = 1'b1; we1 = we; a1 = addr; wd1 = wdata; sz1 = size; end
    n = 0;
    while (((sel == 0) ? rdy0 : rdy1) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got ready=0 expected ready=1 within 100 cycles", tag);
    end
    e.cyc   = cyc + 1 + w + 1;
    e.err   = exp_err;
    e.rdata = exp_rd;
    e.tag   = tag;
    if (push) begin
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_ready0", {31'b0, rdy0}, 32'd1);
    check("reset_valid0", {31'b0, rv0}, 32'd0);
    check("reset_rdata0", rd0, 32'd0);
    check("reset_err0", {31'b0, er0}, 32'd0);
    check("reset_ready1", {31'b0, rdy1}, 32'd1);
    arstn = 1'b1;

    // Word store then load; ready must stay low for the four cycles after accept
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 1'b1, "sw_10");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ready_low_%0d", i), {31'b0, rdy0}, 32'd0);
      @(negedge clk);
    end
    check("ready_high_again", {31'b0, rdy0}, 32'd1);
    req(0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 1'b1, "lw_10");

    // Sub-word stores into a zeroed word, then every load flavour
    req(0, 1'b1, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0, 1'b1, "sw_20");
    req(0, 1'b1, 32'h21, 32'h80, 3'b000, 1'b0, 32'h0, 1'b1, "sb_21");
    req(0, 1'b1, 32'h22, 32'h1234, 3'b001, 1'b0, 32'h0, 1'b1, "sh_22");
    req(0, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h12348000, 1'b1, "lw_20");
    req(0, 1'b0, 32'h21, 32'h0, 3'b000, 1'b0, 32'hFFFFFF80, 1'b1, "lb_21");
    req(0, 1'b0, 32'h21, 32'h0, 3'b100, 1'b0, 32'h00000080, 1'b1, "lbu_21");
    req(0, 1'b0, 32'h22, 32'h0, 3'b001, 1'b0, 32'h00001234, 1'b1, "lh_22");

    // Error cases leave memory untouched
    req(0, 1'b0, 32'h13, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, "lw_mis_13");
    req(0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 1'b1, "lw_10_again");
    req(0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 1'b0, 32'h0, 1'b1, "sw_30");
    req(0, 1'b1, 32'h31, 32'hFFFF, 3'b001, 1'b1, 32'h0, 1'b1, "sh_mis_31");
    req(0, 1'b1, 32'h30, 32'hFF, 3'b100, 1'b1, 32'h0, 1'b1, "s_size100");
    req(0, 1'b0, 32'h30, 32'h0, 3'b010, 1'b0, 32'hCAFEF00D, 1'b1, "lw_30");
    req(0, 1'b0, 32'd4096, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, "lw_oor");
    req(0, 1'b0, 32'h10, 32'h0, 3'b011, 1'b1, 32'h0, 1'b1, "l_size011");

    // Reset while a store sits in WAIT: no write may happen
    req(0, 1'b1, 32'h40, 32'h11111111, 3'b010, 1'b0, 32'h0, 1'b1, "sw_40");
    req(0, 1'b1, 32'h40, 32'hAAAAAAAA, 3'b010, 1'b0, 32'h0, 1'b0, "sw_40_dropped");
    #2 arstn = 1'b0;
    #1;
    check("midrst_ready", {31'b0, rdy0}, 32'd1);
    check("midrst_valid", {31'b0, rv0}, 32'd0);
    check("midrst_rdata", rd0, 32'd0);
    check("midrst_err", {31'b0, er0}, 32'd0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    req(0, 1'b0, 32'h40, 32'h0, 3'b010, 1'b0, 32'h11111111, 1'b1, "lw_40_after_rst");

    // Zero-wait instance, back-to-back requests
    rc1.delete();
    req(1, 1'b1, 32'h0, 32'h01020304, 3'b010, 1'b0, 32'h0, 1'b1, "w0_sw_0");
    req(1, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0, 32'h01020304, 1'b1, "w0_lw_0");
    req(1, 1'b0, 32'h2, 32'h0, 3'b101, 1'b0, 32'h00000102, 1'b1, "w0_lhu_2");
    req(1, 1'b0, 32'h3, 32'h0, 3'b000, 1'b0, 32'h00000001, 1'b1, "w0_lb_3");

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("w0_rsp_count", rc1.size(), 32'd4);
    for (int i = 1; i < rc1.size(); i++) begin
      check($sformatf("w0_spacing_%0d", i), rc1[i] - rc1[i-1], 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
